// File: rtl/circ_stagger_engine.sv
// Frame-strobed stagger delay for the CIRC datapath: each symbol lane is delayed by a
// mode-dependent multiple of UNIT frames, with fill-masking of stale lanes as erasures.
module circ_stagger_engine #(
  parameter int WIDTH = 8,
  parameter int WORDS = 28,
  parameter int UNIT  = 4
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         FRAME_VALID,
  input  logic                         MODE,
  input  logic [WORDS-1:0][WIDTH-1:0]  D,
  input  logic [WORDS-1:0]             EIN,
  output logic [WORDS-1:0][WIDTH-1:0]  Q,
  output logic [WORDS-1:0]             EOUT,
  output logic                         Q_VALID,
  output logic                         PRIMED
);

  localparam int MAXD  = (WORDS - 1) * UNIT;
  localparam int DEPTH = MAXD + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam logic [PW-1:0] MAXD_P  = PW'(MAXD);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  typedef enum logic {MODE_DEINT = 1'b0, MODE_INT = 1'b1} mode_e;
  typedef logic [WORDS-1:0][WIDTH:0] frame_t;

  frame_t                      ring_q [DEPTH];
  frame_t                      wr_frame;
  logic [PW-1:0]               wp_q, wp_d;
  logic [PW-1:0]               fc_q, fc_d, fc_eff;
  mode_e                       mode_q, mode_d, mode_sel;
  logic [WORDS-1:0][WIDTH-1:0] q_q, q_d;
  logic [WORDS-1:0]            eout_q, eout_d;
  logic                        qv_q, primed_q;

  // A mode change restarts the fill count within the same frame, so the new delays
  // are masked from the very first frame that uses them.
  always_comb begin
    mode_sel = FRAME_VALID ? mode_e'(MODE) : mode_q;
    fc_eff   = (mode_sel != mode_q) ? '0 : fc_q;
    mode_d   = mode_sel;
    wp_d     = wp_q;
    fc_d     = fc_q;
    if (FRAME_VALID) begin
      wp_d = (wp_q == MAXD_P) ? '0 : wp_q + ONE_P;
      fc_d = (fc_eff == MAXD_P) ? fc_eff : fc_eff + ONE_P;
    end
  end

  for (genvar g = 0; g < WORDS; g++) begin : g_lane
    localparam logic [PW-1:0] DEL_DEINT = PW'((WORDS - 1 - g) * UNIT);
    localparam logic [PW-1:0] DEL_INT   = PW'(g * UNIT);

    logic [PW-1:0] delay;
    logic [PW-1:0] rd_idx;
    logic [WIDTH:0] sym;
    logic           masked;

    assign wr_frame[g] = {EIN[g], D[g]};

    // Modular subtract: when DEPTH is a power of two DEPTH_P truncates to zero and
    // the PW-bit wrap alone gives the right slot.
    always_comb begin
      delay  = (mode_sel == MODE_INT) ? DEL_INT : DEL_DEINT;
      rd_idx = (wp_q >= delay) ? (wp_q - delay) : (wp_q - delay + DEPTH_P);
      sym    = (delay == '0) ? wr_frame[g] : ring_q[rd_idx][g];
      masked = (fc_eff < delay);
    end

    assign q_d[g]    = masked ? '0 : sym[WIDTH-1:0];
    assign eout_d[g] = sym[WIDTH] | masked;
  end

  // Ring storage is deliberately unreset; stale slots are hidden by the fill mask.
  always_ff @(posedge CLK) begin
    if (FRAME_VALID) begin
      ring_q[wp_q] <= wr_frame;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wp_q     <= '0;
      fc_q     <= '0;
      mode_q   <= MODE_DEINT;
      q_q      <= '0;
      eout_q   <= '1;
      qv_q     <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      wp_q     <= wp_d;
      fc_q     <= fc_d;
      mode_q   <= mode_d;
      qv_q     <= FRAME_VALID;
      primed_q <= (fc_q == MAXD_P);
      if (FRAME_VALID) begin
        q_q    <= q_d;
        eout_q <= eout_d;
      end
    end
  end

  assign Q       = q_q;
  assign EOUT    = eout_q;
  assign Q_VALID = qv_q;
  assign PRIMED  = primed_q;

endmodule

// File: tb/tb_circ_stagger_engine.sv
// Directed bench for circ_stagger_engine: default instance, interleave->deinterleave
// chain, and a small WIDTH=4/WORDS=3/UNIT=1 instance.
module tb_circ_stagger_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic             fv_a, mode_a;
  logic [27:0][7:0] d_a, q_a, q_b;
  logic [27:0]      ein_a, eout_a, eout_b;
  logic             qv_a, primed_a, qv_b, primed_b;

  logic             fv_s, mode_s;
  logic [2:0][3:0]  d_s, q_s;
  logic [2:0]       ein_s, eout_s;
  logic             qv_s, primed_s;

  circ_stagger_engine u_a (
    .CLK(clk), .RST_N(rst_n), .FRAME_VALID(fv_a), .MODE(mode_a), .D(d_a), .EIN(ein_a),
    .Q(q_a), .EOUT(eout_a), .Q_VALID(qv_a), .PRIMED(primed_a)
  );

  circ_stagger_engine u_b (
    .CLK(clk), .RST_N(rst_n), .FRAME_VALID(qv_a), .MODE(1'b0), .D(q_a), .EIN(eout_a),
    .Q(q_b), .EOUT(eout_b), .Q_VALID(qv_b), .PRIMED(primed_b)
  );

  circ_stagger_engine #(.WIDTH(4), .WORDS(3), .UNIT(1)) u_s (
    .CLK(clk), .RST_N(rst_n), .FRAME_VALID(fv_s), .MODE(mode_s), .D(d_s), .EIN(ein_s),
    .Q(q_s), .EOUT(eout_s), .Q_VALID(qv_s), .PRIMED(primed_s)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int n, input int i);
    return {n[3:0], i[3:0]};
  endfunction

  function automatic logic [3:0] sd(input int n, input int i);
    int t;
    t = n + 5 * i;
    return t[3:0];
  endfunction

  // Expected default-instance output for frame n: lane i shows input frame n-delay_i,
  // erased when that frame precedes the start of the current same-mode stream.
  task automatic exp_a(input int n, input bit md, input int start, input int efr,
                       input int eln, output logic [27:0][7:0] eq, output logic [27:0] ee);
    for (int i = 0; i < 28; i++) begin
      int d, src;
      d   = md ? 4 * i : 4 * (27 - i);
      src = n - d;
      if (src < start) begin
        eq[i] = '0;
        ee[i] = 1'b1;
      end else begin
        eq[i] = pat(src, i);
        ee[i] = (src == efr) && (i == eln);
      end
    end
  endtask

  task automatic push_a(input int n, input bit md, input logic [27:0] ein);
    fv_a   = 1'b1;
    mode_a = md;
    for (int i = 0; i < 28; i++) d_a[i] = pat(n, i);
    ein_a  = ein;
    @(posedge clk);
    #1;
    fv_a  = 1'b0;
    ein_a = '0;
  endtask

  task automatic check_a(input int n, input bit md, input int start, input int efr,
                         input bit qv, input bit pr);
    logic [27:0][7:0] eq;
    logic [27:0]      ee;
    exp_a(n, md, start, efr, 5, eq, ee);
    chk($sformatf("a_q@%0d", n), 256'(q_a), 256'(eq));
    chk($sformatf("a_eout@%0d", n), 256'(eout_a), 256'(ee));
    chk($sformatf("a_qvalid@%0d", n), 256'(qv_a), 256'(qv));
    chk($sformatf("a_primed@%0d", n), 256'(primed_a), 256'(pr));
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, "_q"}, 256'(q_a), 256'(0));
    chk({tag, "_eout"}, 256'(eout_a), 256'(28'hFFFFFFF));
    chk({tag, "_qvalid"}, 256'(qv_a), 256'(0));
    chk({tag, "_primed"}, 256'(primed_a), 256'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    fv_a = 1'b0; mode_a = 1'b0; d_a = '0; ein_a = '0;
    fv_s = 1'b0; mode_s = 1'b0; d_s = '0; ein_s = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_a("reset");
    chk("s_reset_eout", 256'(eout_s), 256'(3'b111));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Deinterleave fill and priming, with a single erased symbol on frame 150 lane 5.
    for (int n = 0; n < 300; n++) begin
      push_a(n, 1'b0, (n == 150) ? 28'(1 << 5) : 28'(0));
      check_a(n, 1'b0, 0, 150, 1'b1, n >= 108);
    end

    // Switch to interleave at frame 300: lanes refill from scratch, lane 0 never masked.
    for (int n = 300; n <= 420; n++) begin
      push_a(n, 1'b1, '0);
      check_a(n, 1'b1, 300, 150, 1'b1, (n == 300) || (n >= 408));
    end

    // Asynchronous reset between clock edges, outputs must clear without a clock.
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_a("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Gapped strobes, one frame in seven; delays are counted in frames.
    for (int n = 0; n <= 120; n++) begin
      push_a(n, 1'b0, '0);
      check_a(n, 1'b0, 0, -1, 1'b1, n >= 108);
      for (int k = 0; k < 6; k++) begin
        @(posedge clk);
        #1;
        check_a(n, 1'b0, 0, -1, 1'b0, n >= 107);
      end
    end

    // Interleaver feeding a deinterleaver: original stream reappears 108 frames later.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 0; n < 230; n++) begin
      logic [27:0][7:0] eq;
      logic [27:0]      ee;
      int m;
      push_a(n, 1'b1, '0);
      check_a(n, 1'b1, 0, -1, 1'b1, n >= 108);
      m = n - 1;
      for (int i = 0; i < 28; i++) begin
        eq[i] = (m < 108) ? 8'h00 : pat(m - 108, i);
        ee[i] = (m < 108);
      end
      chk($sformatf("b_q@%0d", m), 256'(q_b), 256'(eq));
      chk($sformatf("b_eout@%0d", m), 256'(eout_b), 256'(ee));
      chk($sformatf("b_qvalid@%0d", m), 256'(qv_b), 256'(n >= 1));
      chk($sformatf("b_primed@%0d", m), 256'(primed_b), 256'(m >= 108));
    end

    // Small instance: delays 2,1,0 with a three-slot ring wrapping every three frames.
    for (int n = 0; n < 20; n++) begin
      logic [2:0][3:0] eq;
      logic [2:0]      ee;
      if (n == 10) begin
        @(posedge clk);
        #1;
        chk("s_gap_qvalid", 256'(qv_s), 256'(0));
      end
      fv_s   = 1'b1;
      mode_s = 1'b0;
      for (int i = 0; i < 3; i++) d_s[i] = sd(n, i);
      ein_s  = (n == 7) ? 3'b010 : ((n == 12) ? 3'b100 : 3'b000);
      @(posedge clk);
      #1;
      fv_s  = 1'b0;
      ein_s = '0;
      for (int i = 0; i < 3; i++) begin
        int src;
        src = n - (2 - i);
        if (src < 0) begin
          eq[i] = '0;
          ee[i] = 1'b1;
        end else begin
          eq[i] = sd(src, i);
          ee[i] = ((src == 7) && (i == 1)) || ((src == 12) && (i == 2));
        end
      end
      chk($sformatf("s_q@%0d", n), 256'(q_s), 256'(eq));
      chk($sformatf("s_eout@%0d", n), 256'(eout_s), 256'(ee));
      chk($sformatf("s_qvalid@%0d", n), 256'(qv_s), 256'(1));
      chk($sformatf("s_primed@%0d", n), 256'(primed_s), 256'(n >= 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
